inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_pkg.sv | 17 +
 rtl/inst_loader_uart_rx.sv | 121 ++++++++++++
 rtl/inst_loader.sv | 105 ++++++++++
 tb/tb_inst_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the UART instruction loader: receiver states and protocol constants.
package inst_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  // Word that terminates a load session.
  localparam logic [31:0] END_MARKER = 32'h0000_003F;

  // Value of the mode input that enables byte acceptance.
  localparam logic LOAD = 1'b1;

endpackage

// File: rtl/inst_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, half-bit start qualification and mid-bit sampling.
// o_valid / o_ferr are one-cycle strobes in the cycle the stop bit is sampled, so the
// consumer can register its response into the very next cycle.
module uart_rx
  import inst_loader_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_ferr
);

  localparam int unsigned TW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_PER_HALF_BIT - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(2 * CLK_PER_HALF_BIT - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;
  rx_state_e       r_state;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_wait;

  logic            w_rx;
  logic            w_fall;
  logic            w_half_hit;
  logic            w_full_hit;
  logic            w_stop_sample;

  assign w_rx          = r_sync2;
  assign w_fall        = r_prev & ~r_sync2;
  assign w_half_hit    = (r_timer == HALF_LAST);
  assign w_full_hit    = (r_timer == FULL_LAST);
  assign w_stop_sample = (r_state == StStop) && !r_wait && w_full_hit;

  assign o_byte  = r_shift;
  assign o_valid = w_stop_sample && w_rx;
  assign o_ferr  = w_stop_sample && !w_rx;

  // Synchronize the asynchronous line and keep one extra stage for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Receiver FSM: qualify the start bit, shift data LSB first, check the stop bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_wait    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_fall) begin
            r_state <= StStart;
            r_timer <= '0;
          end
        end
        StStart: begin
          if (w_half_hit) begin
            r_timer   <= '0;
            r_bit_cnt <= '0;
            // A line already back high is a glitch, not a start bit.
            r_state   <= w_rx ? StIdle : StData;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        StData: begin
          if (w_full_hit) begin
            r_timer <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= StStop;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        StStop: begin
          if (r_wait) begin
            // After a framing error, hold off until the line returns to idle.
            if (w_rx) begin
              r_wait  <= 1'b0;
              r_state <= StIdle;
            end
          end else if (w_full_hit) begin
            r_timer <= '0;
            if (w_rx) begin
              r_state <= StIdle;
            end else begin
              r_wait <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: receives bytes over UART, packs them big-endian into 32-bit words and
// writes them to sequential instruction-memory addresses until the end marker arrives.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 434,
  parameter int unsigned INST_SIZE        = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 mode,
  output logic                 we,
  output logic [INST_SIZE-1:0] waddr,
  output logic [31:0]          wdata,
  output logic                 done,
  output logic                 err
);

  localparam logic [INST_SIZE-1:0] LAST_ADDR = '1;

  logic [7:0]           w_byte;
  logic                 w_valid;
  logic                 w_ferr;
  logic                 w_active;
  logic                 w_mode_fall;

  logic [1:0]           r_byte_cnt;
  logic [31:0]          r_wdata;
  logic [INST_SIZE-1:0] r_waddr;
  logic                 r_we;
  logic                 r_done;
  logic                 r_err;
  logic                 r_full;
  logic                 r_mode_q;

  uart_rx #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_rx (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_rxd  (rxd),
    .o_byte (w_byte),
    .o_valid(w_valid),
    .o_ferr (w_ferr)
  );

  assign w_active    = (mode == LOAD) && !r_done;
  assign w_mode_fall = (r_mode_q == LOAD) && (mode != LOAD);

  assign we    = r_we;
  assign waddr = r_waddr;
  assign wdata = r_wdata;
  assign done  = r_done;
  assign err   = r_err;

  // Word assembly, write strobe, address advance and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_wdata    <= '0;
      r_waddr    <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_full     <= 1'b0;
      r_mode_q   <= 1'b0;
    end else begin
      r_we     <= 1'b0;
      r_mode_q <= mode;

      // Address moves on only after the write cycle so waddr is stable while we is high.
      if (r_we) begin
        if (r_wdata == END_MARKER) begin
          r_done <= 1'b1;
        end
        if (r_waddr == LAST_ADDR) begin
          r_full <= 1'b1;
        end else begin
          r_waddr <= r_waddr + INST_SIZE'(1);
        end
      end

      if (w_mode_fall) begin
        r_byte_cnt <= '0;
      end else if (w_active) begin
        if (w_ferr) begin
          r_err <= 1'b1;
        end
        if (w_valid) begin
          r_wdata    <= {r_wdata[23:0], w_byte};
          r_byte_cnt <= r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            if (r_full) begin
              r_err <= 1'b1;
            end else begin
              r_we <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: two instances (INST_SIZE 10 and 2) with 4 clocks per half bit.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int H   = 4;
  localparam int BIT = 2 * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, rxd_a = 1'b1, mode_a = 1'b1;
  logic        we_a, done_a, err_a;
  logic [9:0]  waddr_a;
  logic [31:0] wdata_a;

  logic        rst_b = 1'b1, rxd_b = 1'b1, mode_b = 1'b1;
  logic        we_b, done_b, err_b;
  logic [1:0]  waddr_b;
  logic [31:0] wdata_b;

  inst_loader #(.CLK_PER_HALF_BIT(H), .INST_SIZE(10)) dut_a (
    .clk(clk), .rst(rst_a), .rxd(rxd_a), .mode(mode_a), .we(we_a),
    .waddr(waddr_a), .wdata(wdata_a), .done(done_a), .err(err_a)
  );

  inst_loader #(.CLK_PER_HALF_BIT(H), .INST_SIZE(2)) dut_b (
    .clk(clk), .rst(rst_b), .rxd(rxd_b), .mode(mode_b), .we(we_b),
    .waddr(waddr_b), .wdata(wdata_b), .done(done_b), .err(err_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log per instance, sampled mid-cycle; counts cycles with we high.
  int          we_cnt_a = 0, we_cnt_b = 0;
  int          addr_log_a [64], addr_log_b [64], we_cyc_a [64];
  logic [31:0] data_log_a [64], data_log_b [64];
  int          done_rise_a = -1;
  logic        done_prev_a = 1'b0;

  always @(negedge clk) begin
    if (we_a === 1'b1 && we_cnt_a < 64) begin
      addr_log_a[we_cnt_a] <= int'(waddr_a);
      data_log_a[we_cnt_a] <= wdata_a;
      we_cyc_a[we_cnt_a]   <= cyc;
      we_cnt_a             <= we_cnt_a + 1;
    end
    if (we_b === 1'b1 && we_cnt_b < 64) begin
      addr_log_b[we_cnt_b] <= int'(waddr_b);
      data_log_b[we_cnt_b] <= wdata_b;
      we_cnt_b             <= we_cnt_b + 1;
    end
    if (done_a === 1'b1 && done_prev_a !== 1'b1) done_rise_a <= cyc;
    done_prev_a <= done_a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input logic sel_b, input string tag);
    if (sel_b) begin
      check($sformatf("%s_we", tag), 32'(we_b), 32'd0);
      check($sformatf("%s_waddr", tag), 32'(waddr_b), 32'd0);
      check($sformatf("%s_wdata", tag), wdata_b, 32'd0);
      check($sformatf("%s_done", tag), 32'(done_b), 32'd0);
      check($sformatf("%s_err", tag), 32'(err_b), 32'd0);
    end else begin
      check($sformatf("%s_we", tag), 32'(we_a), 32'd0);
      check($sformatf("%s_waddr", tag), 32'(waddr_a), 32'd0);
      check($sformatf("%s_wdata", tag), wdata_a, 32'd0);
      check($sformatf("%s_done", tag), 32'(done_a), 32'd0);
      check($sformatf("%s_err", tag), 32'(err_a), 32'd0);
    end
  endtask

  task automatic drive(input logic sel_b, input logic v);
    if (sel_b) rxd_b = v;
    else       rxd_a = v;
  endtask

  task automatic send_bit(input logic sel_b, input logic v);
    drive(sel_b, v);
    repeat (BIT) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, stop bit, then two idle bit times.
  task automatic send_byte(input logic sel_b, input logic [7:0] b, input logic stop);
    send_bit(sel_b, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel_b, b[i]);
    send_bit(sel_b, stop);
    send_bit(sel_b, 1'b1);
    send_bit(sel_b, 1'b1);
  endtask

  task automatic send_word(input logic sel_b, input logic [31:0] w);
    send_byte(sel_b, w[31:24], 1'b1);
    send_byte(sel_b, w[23:16], 1'b1);
    send_byte(sel_b, w[15:8], 1'b1);
    send_byte(sel_b, w[7:0], 1'b1);
  endtask

  task automatic reset_a(input string tag);
    @(negedge clk);
    rst_a = 1'b1; rxd_a = 1'b1; mode_a = 1'b1;
    repeat (3) @(negedge clk);
    check_zero(1'b0, tag);
    rst_a = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int base;

  initial begin
    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check_zero(1'b0, "rst_a");
    check_zero(1'b1, "rst_b");
    rst_a = 1'b0;
    repeat (4) @(negedge clk);

    // Four bytes make one word at address 0.
    base = we_cnt_a;
    send_word(1'b0, 32'h1234_5678);
    check("w1_we_count", 32'(we_cnt_a - base), 32'd1);
    check("w1_addr", 32'(addr_log_a[base]), 32'd0);
    check("w1_data", data_log_a[base], 32'h1234_5678);
    check("w1_waddr_after", 32'(waddr_a), 32'd1);
    check("w1_err", 32'(err_a), 32'd0);

    // Short low glitch is rejected without error.
    base = we_cnt_a;
    rxd_a = 1'b0;
    repeat (3) @(negedge clk);
    rxd_a = 1'b1;
    repeat (4 * BIT) @(negedge clk);
    check("glitch_we", 32'(we_cnt_a - base), 32'd0);
    check("glitch_err", 32'(err_a), 32'd0);
    check("glitch_idle", 32'(dut_a.u_rx.r_state), 32'(StIdle));

    // Data word, end marker, then a trailing byte that must be ignored.
    reset_a("rst2");
    base = we_cnt_a;
    send_word(1'b0, 32'hDEAD_BEEF);
    send_word(1'b0, 32'h0000_003F);
    check("mk_we_count", 32'(we_cnt_a - base), 32'd2);
    check("mk_addr0", 32'(addr_log_a[base]), 32'd0);
    check("mk_data0", data_log_a[base], 32'hDEAD_BEEF);
    check("mk_addr1", 32'(addr_log_a[base + 1]), 32'd1);
    check("mk_data1", data_log_a[base + 1], 32'h0000_003F);
    check("mk_done_delay", 32'(done_rise_a - we_cyc_a[base + 1]), 32'd1);
    send_byte(1'b0, 8'hAA, 1'b1);
    check("mk_after_we", 32'(we_cnt_a - base), 32'd2);
    check("mk_done_sticky", 32'(done_a), 32'd1);

    // Framing error: err set, byte not counted.
    reset_a("rst3");
    base = we_cnt_a;
    send_byte(1'b0, 8'h55, 1'b0);
    check("fe_err", 32'(err_a), 32'd1);
    check("fe_we", 32'(we_cnt_a - base), 32'd0);
    send_word(1'b0, 32'h0102_0304);
    check("fe_we_count", 32'(we_cnt_a - base), 32'd1);
    check("fe_data", data_log_a[base], 32'h0102_0304);
    check("fe_addr", 32'(addr_log_a[base]), 32'd0);
    check("fe_err_sticky", 32'(err_a), 32'd1);

    // Partial byte cleared by mode falling; bytes ignored while mode=0.
    reset_a("rst4");
    base = we_cnt_a;
    send_byte(1'b0, 8'h99, 1'b1);
    mode_a = 1'b0;
    send_byte(1'b0, 8'h11, 1'b1);
    send_byte(1'b0, 8'h22, 1'b1);
    mode_a = 1'b1;
    send_word(1'b0, 32'hA1B2_C3D4);
    check("md_we_count", 32'(we_cnt_a - base), 32'd1);
    check("md_data", data_log_a[base], 32'hA1B2_C3D4);
    check("md_addr", 32'(addr_log_a[base]), 32'd0);

    // Small memory: four writes, fifth word dropped with err.
    @(negedge clk);
    rst_b = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 5; i++) send_word(1'b1, 32'h0101_0101 * i);
    check("ov_we_count", 32'(we_cnt_b), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ov_addr%0d", i), 32'(addr_log_b[i]), 32'(i));
      check($sformatf("ov_data%0d", i), data_log_b[i], 32'h0101_0101 * (i + 1));
    end
    check("ov_err", 32'(err_b), 32'd1);
    check("ov_waddr_hold", 32'(waddr_b), 32'd3);

    // Reset in the middle of a byte clears everything; next word lands at 0.
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    rst_b = 1'b1;
    rxd_b = 1'b1;
    @(negedge clk);
    check_zero(1'b1, "midrst");
    rst_b = 1'b0;
    repeat (4) @(negedge clk);
    send_word(1'b1, 32'h0A0B_0C0D);
    check("post_we_count", 32'(we_cnt_b), 32'd5);
    check("post_addr", 32'(addr_log_b[4]), 32'd0);
    check("post_data", data_log_b[4], 32'h0A0B_0C0D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
